// File: rtl/io_pkg.sv
// Shared constants for the board I/O conditioning path.
//   N_SW / N_BTN       : channel counts (16 slide switches, 5 push buttons)
//   BTN_*              : button bit positions, order {C,U,L,R,D} = [4:0]
//   DEF_STABLE_CYCLES  : default qualification time (10 ms at 100 MHz)
//   DEF_CNT_W          : default counter width, 2^DEF_CNT_W > DEF_STABLE_CYCLES
package io_pkg;

    localparam int unsigned N_SW  = 16;
    localparam int unsigned N_BTN = 5;

    localparam int unsigned BTN_C = 4;
    localparam int unsigned BTN_U = 3;
    localparam int unsigned BTN_L = 2;
    localparam int unsigned BTN_R = 1;
    localparam int unsigned BTN_D = 0;

    localparam int unsigned DEF_STABLE_CYCLES = 1000000;
    localparam int unsigned DEF_CNT_W         = 24;

endpackage

// File: rtl/input_debounce_if.sv
// Pin-side / consumer-side bundle of the input conditioning stage.
//   sw_raw, btn_raw : raw asynchronous pins (btn 1 = pressed)
//   sw, btn         : debounced levels
//   btn_press       : one-cycle pulse per debounced button press
//   sw_chg          : one-cycle pulse after any debounced switch change
// master drives the raw pins and observes the results; slave is the debouncer.
interface input_debounce_if #(
    parameter int unsigned N_SW  = io_pkg::N_SW,
    parameter int unsigned N_BTN = io_pkg::N_BTN
);
    logic [N_SW-1:0]  sw_raw;
    logic [N_BTN-1:0] btn_raw;
    logic [N_SW-1:0]  sw;
    logic [N_BTN-1:0] btn;
    logic [N_BTN-1:0] btn_press;
    logic             sw_chg;

    modport master (
        output sw_raw, btn_raw,
        input  sw, btn, btn_press, sw_chg
    );

    modport slave (
        input  sw_raw, btn_raw,
        output sw, btn, btn_press, sw_chg
    );
endinterface

// File: rtl/debounce_cell.sv
// Single-channel debouncer: two-flop synchronizer followed by a stability
// counter. The output follows the synchronized level only after it has
// differed from the current output for STABLE_CYCLES consecutive edges.
//   clk  : system clock
//   rstn : synchronous active-low reset
//   raw  : asynchronous input pin
//   out  : debounced, registered level
module debounce_cell #(
    parameter int unsigned STABLE_CYCLES = io_pkg::DEF_STABLE_CYCLES,
    parameter int unsigned CNT_W         = io_pkg::DEF_CNT_W
) (
    input  logic clk,
    input  logic rstn,
    input  logic raw,
    output logic out
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             out_q, out_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        s1_d  = raw;
        s2_d  = s1_q;
        out_d = out_q;
        cnt_d = cnt_q;
        // Any sample agreeing with the current output restarts qualification.
        if (s2_q == out_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            out_d = s2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            out_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            out_q <= out_d;
            cnt_q <= cnt_d;
        end
    end

    assign out = out_q;

endmodule

// File: rtl/input_debounce.sv
// Conditioning stage between the board pins and the I/O unit. Every switch
// and button channel gets its own debounce_cell; on top of the clean levels
// this module derives registered press pulses and a switch-change pulse.
//   clk  : system clock
//   rstn : synchronous active-low reset
//   io   : slave side of input_debounce_if (raw pins in, clean signals out)
module input_debounce #(
    parameter int unsigned STABLE_CYCLES = io_pkg::DEF_STABLE_CYCLES,
    parameter int unsigned CNT_W         = io_pkg::DEF_CNT_W,
    parameter int unsigned N_SW          = io_pkg::N_SW,
    parameter int unsigned N_BTN         = io_pkg::N_BTN
) (
    input  logic             clk,
    input  logic             rstn,
    input_debounce_if.slave  io
);
    logic [N_SW-1:0]  sw_lvl;
    logic [N_BTN-1:0] btn_lvl;

    logic [N_SW-1:0]  sw_prev_q, sw_prev_d;
    logic [N_BTN-1:0] btn_prev_q, btn_prev_d;
    logic [N_BTN-1:0] btn_press_q, btn_press_d;
    logic             sw_chg_q, sw_chg_d;

    for (genvar i = 0; i < N_SW; i++) begin : g_sw
        debounce_cell #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .CNT_W         (CNT_W)
        ) u_cell (
            .clk  (clk),
            .rstn (rstn),
            .raw  (io.sw_raw[i]),
            .out  (sw_lvl[i])
        );
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        debounce_cell #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .CNT_W         (CNT_W)
        ) u_cell (
            .clk  (clk),
            .rstn (rstn),
            .raw  (io.btn_raw[i]),
            .out  (btn_lvl[i])
        );
    end

    // Previous-cycle copies of the clean levels are cleared together with the
    // cells, so neither reset entry nor exit can produce a spurious pulse.
    always_comb begin
        sw_prev_d   = sw_lvl;
        btn_prev_d  = btn_lvl;
        btn_press_d = btn_lvl & ~btn_prev_q;
        sw_chg_d    = |(sw_lvl ^ sw_prev_q);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sw_prev_q   <= '0;
            btn_prev_q  <= '0;
            btn_press_q <= '0;
            sw_chg_q    <= 1'b0;
        end else begin
            sw_prev_q   <= sw_prev_d;
            btn_prev_q  <= btn_prev_d;
            btn_press_q <= btn_press_d;
            sw_chg_q    <= sw_chg_d;
        end
    end

    assign io.sw        = sw_lvl;
    assign io.btn       = btn_lvl;
    assign io.btn_press = btn_press_q;
    assign io.sw_chg    = sw_chg_q;

endmodule

// File: tb/tb_input_debounce.sv
module tb_input_debounce;

    localparam int unsigned SC = 4;
    localparam int unsigned CW = 3;

    logic clk = 1'b0;
    logic rstn = 1'b0;

    always #5 clk = ~clk;

    input_debounce_if #(.N_SW(16), .N_BTN(5)) io ();

    input_debounce #(
        .STABLE_CYCLES (SC),
        .CNT_W         (CW),
        .N_SW          (16),
        .N_BTN         (5)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .io   (io)
    );

    typedef struct {
        logic        rstn;
        logic [15:0] sw_raw;
        logic [4:0]  btn_raw;
        logic [15:0] e_sw;
        logic [4:0]  e_btn;
        logic [4:0]  e_press;
        logic        e_chg;
    } vec_t;

    vec_t vt[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic r, input logic [15:0] swr, input logic [4:0] btr,
                       input logic [15:0] esw, input logic [4:0] ebt,
                       input logic [4:0] epr, input logic ech);
        vec_t v;
        v.rstn = r; v.sw_raw = swr; v.btn_raw = btr;
        v.e_sw = esw; v.e_btn = ebt; v.e_press = epr; v.e_chg = ech;
        vt.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One active edge, then sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int press_cnt;
        int chg_cnt;

        io.sw_raw  = '0;
        io.btn_raw = '0;

        // Reset held with all inputs high, then release: everything qualifies after edge 5.
        repeat (3) add(0, 16'hFFFF, 5'h1F, 16'h0000, 5'h00, 5'h00, 0);
        repeat (5) add(1, 16'hFFFF, 5'h1F, 16'h0000, 5'h00, 5'h00, 0);
        add(1, 16'hFFFF, 5'h1F, 16'hFFFF, 5'h1F, 5'h00, 0);
        add(1, 16'hFFFF, 5'h1F, 16'hFFFF, 5'h1F, 5'h1F, 1);
        add(1, 16'hFFFF, 5'h1F, 16'hFFFF, 5'h1F, 5'h00, 0);
        // Release all buttons: no press pulse on the falling edge.
        repeat (5) add(1, 16'hFFFF, 5'h00, 16'hFFFF, 5'h1F, 5'h00, 0);
        repeat (2) add(1, 16'hFFFF, 5'h00, 16'hFFFF, 5'h00, 5'h00, 0);
        // Clean press of button C.
        repeat (5) add(1, 16'hFFFF, 5'h10, 16'hFFFF, 5'h00, 5'h00, 0);
        add(1, 16'hFFFF, 5'h10, 16'hFFFF, 5'h10, 5'h00, 0);
        add(1, 16'hFFFF, 5'h10, 16'hFFFF, 5'h10, 5'h10, 0);
        add(1, 16'hFFFF, 5'h10, 16'hFFFF, 5'h10, 5'h00, 0);
        // Release of button C.
        repeat (5) add(1, 16'hFFFF, 5'h00, 16'hFFFF, 5'h10, 5'h00, 0);
        repeat (2) add(1, 16'hFFFF, 5'h00, 16'hFFFF, 5'h00, 5'h00, 0);

        for (int i = 0; i < vt.size(); i++) begin
            rstn       = vt[i].rstn;
            io.sw_raw  = vt[i].sw_raw;
            io.btn_raw = vt[i].btn_raw;
            step();
            chk($sformatf("vec%0d.sw", i),    32'(io.sw),        32'(vt[i].e_sw));
            chk($sformatf("vec%0d.btn", i),   32'(io.btn),       32'(vt[i].e_btn));
            chk($sformatf("vec%0d.press", i), 32'(io.btn_press), 32'(vt[i].e_press));
            chk($sformatf("vec%0d.chg", i),   32'(io.sw_chg),    32'(vt[i].e_chg));
        end

        // Bounce on button L: 1,0,1,0 then final rise held.
        io.btn_raw[2] = 1'b1; step();
        io.btn_raw[2] = 1'b0; step();
        io.btn_raw[2] = 1'b1; step();
        io.btn_raw[2] = 1'b0; step();
        io.btn_raw[2] = 1'b1;
        press_cnt = 0;
        for (int e = 0; e < 10; e++) begin
            step();
            chk($sformatf("bounce.btn2.e%0d", e), 32'(io.btn[2]), 32'(e >= 5));
            chk($sformatf("bounce.press2.e%0d", e), 32'(io.btn_press[2]), 32'(e == 6));
            if (io.btn_press[2]) press_cnt++;
        end
        chk("bounce.press_count", 32'(press_cnt), 32'd1);
        io.btn_raw = '0;
        repeat (8) step();
        chk("bounce.released", 32'(io.btn), 32'd0);

        // Bring switches low, then glitch sw[7] for 3 cycles.
        io.sw_raw = '0;
        repeat (8) step();
        chk("glitch.pre_sw", 32'(io.sw), 32'd0);
        io.sw_raw[7] = 1'b1;
        repeat (3) step();
        io.sw_raw[7] = 1'b0;
        chg_cnt = 0;
        for (int e = 0; e < 10; e++) begin
            chk($sformatf("glitch.sw.e%0d", e), 32'(io.sw), 32'd0);
            if (io.sw_chg) chg_cnt++;
            step();
        end
        chk("glitch.chg_count", 32'(chg_cnt), 32'd0);

        // Simultaneous multi-bit switch change.
        io.sw_raw = 16'hA5A5;
        chg_cnt = 0;
        for (int e = 0; e < 10; e++) begin
            step();
            chk($sformatf("simul.sw.e%0d", e), 32'(io.sw), (e >= 5) ? 32'h0000A5A5 : 32'd0);
            chk($sformatf("simul.chg.e%0d", e), 32'(io.sw_chg), 32'(e == 6));
            if (io.sw_chg) chg_cnt++;
        end
        chk("simul.chg_count", 32'(chg_cnt), 32'd1);

        // Reset mid-count on button D.
        io.btn_raw[0] = 1'b1;
        for (int e = 0; e < 3; e++) begin
            step();
            chk($sformatf("rstmid.btn0.e%0d", e), 32'(io.btn[0]), 32'd0);
        end
        rstn = 1'b0;
        step();
        chk("rstmid.btn0.e3", 32'(io.btn[0]), 32'd0);
        chk("rstmid.press0.e3", 32'(io.btn_press[0]), 32'd0);
        rstn = 1'b1;
        for (int e = 4; e < 13; e++) begin
            step();
            chk($sformatf("rstmid.btn0.e%0d", e), 32'(io.btn[0]), 32'(e >= 9));
            chk($sformatf("rstmid.press0.e%0d", e), 32'(io.btn_press[0]), 32'(e == 10));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
